// File: rtl/elevator_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : elevator_scheduler_pkg
// Brief   : Shared state encoding and helpers for the elevator scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package elevator_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_scheduler_call_locator.sv
`default_nettype none
// ============================================================================
// Module  : call_locator
// Brief   : Reports outstanding calls above, below and at a given floor.
// Revision: 1.0 - initial release
// ============================================================================
module call_locator
    import elevator_scheduler_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
) (
    input  logic [FLOORS-1:0]  pending,
    input  logic [FLOOR_W-1:0] current_floor,
    output logic               any_above,
    output logic               any_below,
    output logic               here
);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        here      = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(current_floor)) begin
                any_above = any_above | pending[i];
            end
            if (i < int'(current_floor)) begin
                any_below = any_below | pending[i];
            end
            if (i == int'(current_floor)) begin
                here = pending[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : elevator_scheduler
// Brief   : Single-car SCAN elevator controller (IDLE / MOVE / DOOR).
// Revision: 1.0 - initial release
// ============================================================================
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int FLOORS      = 8,
    parameter int FLOOR_W     = 3,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  call_req,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               going_up,
    output logic               moving,
    output logic               door_open,
    output logic [FLOORS-1:0]  pending
);

    localparam int c_cnt_max = max_int(MOVE_CYCLES, DOOR_CYCLES);
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_move_load = c_cnt_w'(MOVE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_door_load = c_cnt_w'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0]  c_floor_one = {{(FLOORS-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FLOOR_W-1:0]   r_floor;
    logic [FLOOR_W-1:0]   w_floor_nxt;
    logic                 r_going_up;
    logic                 w_up_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [FLOORS-1:0]    r_pending;
    logic [FLOORS-1:0]    w_pending_nxt;
    logic [FLOORS-1:0]    w_clear;

    logic                 w_arrive;
    logic [FLOOR_W-1:0]   w_step_floor;
    logic [FLOOR_W-1:0]   w_eval_floor;
    logic                 w_any_above;
    logic                 w_any_below;
    logic                 w_here;
    logic                 w_ahead;
    logic                 w_behind;
    state_t               w_scan_state;
    logic                 w_scan_up;
    logic [c_cnt_w-1:0]   w_scan_cnt;

    // On an arrival edge the search is done from the floor being entered.
    assign w_arrive     = (r_state == S_MOVE) && (r_cnt == '0);
    assign w_step_floor = r_going_up ? (r_floor + 1'b1) : (r_floor - 1'b1);
    assign w_eval_floor = w_arrive ? w_step_floor : r_floor;

    call_locator #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_call_locator (
        .pending       (r_pending),
        .current_floor (w_eval_floor),
        .any_above     (w_any_above),
        .any_below     (w_any_below),
        .here          (w_here)
    );

    assign w_ahead  = r_going_up ? w_any_above : w_any_below;
    assign w_behind = r_going_up ? w_any_below : w_any_above;

    always_comb begin
        w_scan_state = S_IDLE;
        w_scan_up    = r_going_up;
        w_scan_cnt   = '0;
        if (w_ahead) begin
            w_scan_state = S_MOVE;
            w_scan_cnt   = c_move_load;
        end else if (w_behind) begin
            w_scan_state = S_MOVE;
            w_scan_up    = ~r_going_up;
            w_scan_cnt   = c_move_load;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_floor;
        w_up_nxt    = r_going_up;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_here) begin
                    w_state_nxt = S_DOOR;
                    w_cnt_nxt   = c_door_load;
                end else begin
                    w_state_nxt = w_scan_state;
                    w_up_nxt    = w_scan_up;
                    w_cnt_nxt   = w_scan_cnt;
                end
            end
            S_MOVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_floor_nxt = w_step_floor;
                    if (w_here) begin
                        w_state_nxt = S_DOOR;
                        w_cnt_nxt   = c_door_load;
                    end else begin
                        w_state_nxt = w_scan_state;
                        w_up_nxt    = w_scan_up;
                        w_cnt_nxt   = w_scan_cnt;
                    end
                end
            end
            S_DOOR: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = w_scan_state;
                    w_up_nxt    = w_scan_up;
                    w_cnt_nxt   = w_scan_cnt;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Door floor is cleared on entry and held clear so same-floor calls are absorbed.
    always_comb begin
        w_clear = '0;
        if (w_state_nxt == S_DOOR) begin
            w_clear = w_clear | (c_floor_one << w_floor_nxt);
        end
        if (r_state == S_DOOR) begin
            w_clear = w_clear | (c_floor_one << r_floor);
        end
        w_pending_nxt = (r_pending | call_req) & ~w_clear;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_floor    <= '0;
            r_going_up <= 1'b1;
            r_cnt      <= '0;
            r_pending  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_floor    <= w_floor_nxt;
            r_going_up <= w_up_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pending  <= w_pending_nxt;
        end
    end

    assign current_floor = r_floor;
    assign going_up      = r_going_up;
    assign moving        = (r_state == S_MOVE);
    assign door_open     = (r_state == S_DOOR);
    assign pending       = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_elevator_scheduler
// Brief   : Self-checking bench: vector table, corner sequences, random vs model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

    localparam int MOVE_C = 2;
    localparam int DOOR_C = 4;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] call_req = 8'h00;
    logic [2:0] current_floor;
    logic       going_up;
    logic       moving;
    logic       door_open;
    logic [7:0] pending;

    logic       rst5 = 1'b1;
    logic [4:0] req5 = 5'h00;
    logic [2:0] floor5;
    logic       up5;
    logic       moving5;
    logic       door5;
    logic [4:0] pend5;

    always #5 clk = ~clk;

    elevator_scheduler #(
        .FLOORS(8), .FLOOR_W(3), .MOVE_CYCLES(MOVE_C), .DOOR_CYCLES(DOOR_C)
    ) dut (
        .clk(clk), .reset(rst), .call_req(call_req),
        .current_floor(current_floor), .going_up(going_up),
        .moving(moving), .door_open(door_open), .pending(pending)
    );

    elevator_scheduler #(
        .FLOORS(5), .FLOOR_W(3), .MOVE_CYCLES(1), .DOOR_CYCLES(1)
    ) dut5 (
        .clk(clk), .reset(rst5), .call_req(req5),
        .current_floor(floor5), .going_up(up5),
        .moving(moving5), .door_open(door5), .pending(pend5)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a car with a set of requested floors, a direction, and
    // a count of whole cycles spent in the current activity.
    bit [7:0] m_pend;
    int       m_floor;
    bit       m_up;
    int       m_mode;
    int       m_age;

    function automatic bit has_call(input bit [7:0] p, input int f, input bit upward);
        for (int i = 0; i < 8; i++) begin
            if (p[i] && (upward ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input bit [7:0] req);
        bit [7:0] seen   = m_pend;
        bit [7:0] np     = m_pend | req;
        int       f      = m_floor;
        bit       up     = m_up;
        int       mode   = m_mode;
        int       age    = m_age + 1;
        bit       decide = 1'b0;
        if (m_mode == M_DOOR) np[m_floor] = 1'b0;
        if (m_mode == M_IDLE) begin
            if (seen[f]) begin mode = M_DOOR; age = 0; end
            else decide = 1'b1;
        end else if (m_mode == M_MOVE && age == MOVE_C) begin
            f = up ? f + 1 : f - 1;
            if (seen[f]) begin mode = M_DOOR; age = 0; end
            else decide = 1'b1;
        end else if (m_mode == M_DOOR && age == DOOR_C) begin
            decide = 1'b1;
        end
        if (decide) begin
            age = 0;
            if (has_call(seen, f, up)) mode = M_MOVE;
            else if (has_call(seen, f, !up)) begin up = !up; mode = M_MOVE; end
            else mode = M_IDLE;
        end
        if (mode == M_DOOR) np[f] = 1'b0;
        m_pend  = np;
        m_floor = f;
        m_up    = up;
        m_mode  = mode;
        m_age   = age;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 8'h00; m_floor = 0; m_up = 1'b1; m_mode = M_IDLE; m_age = 0;
        end else begin
            model_edge(call_req);
        end
    end

    task automatic check_model();
        chk("model", {current_floor, going_up, moving, door_open, pending},
            {m_floor[2:0], m_up, (m_mode == M_MOVE), (m_mode == M_DOOR), m_pend});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        call_req = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] req;
        logic [2:0] floor;
        logic       up;
        logic       mv;
        logic       door;
        logic [7:0] pend;
    } vec_t;

    vec_t     vecs[14];
    int       visits[$];
    int       toggles, cyc, dcyc, v0, v1, first_door, door_cnt, max_f;
    logic     found, moved, leak, prev_door, prev_up, door_floor_ok;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // Single call to floor 3 from reset.
        vecs[0]  = '{8'h08, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h08};
        vecs[2]  = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h08};
        vecs[3]  = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h08};
        vecs[4]  = '{8'h00, 3'd1, 1'b1, 1'b1, 1'b0, 8'h08};
        vecs[5]  = '{8'h00, 3'd1, 1'b1, 1'b1, 1'b0, 8'h08};
        vecs[6]  = '{8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 8'h08};
        vecs[7]  = '{8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 8'h08};
        vecs[8]  = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[9]  = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[10] = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[11] = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[12] = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{8'h00, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00};

        @(negedge clk);
        do_reset();
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("vec%0d", k), {current_floor, going_up, moving, door_open, pending},
                {vecs[k].floor, vecs[k].up, vecs[k].mv, vecs[k].door, vecs[k].pend});
            call_req = vecs[k].req;
            @(negedge clk);
        end

        // Call at the resting floor: door, no travel.
        do_reset();
        call_req = 8'h01;
        @(negedge clk);
        call_req = 8'h00;
        chk("here_pend", pending, 8'h01);
        chk("here_door_early", door_open, 1'b0);
        @(negedge clk);
        chk("here_door", {door_open, moving, current_floor, going_up}, {1'b1, 1'b0, 3'd0, 1'b1});
        moved = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (moving || current_floor != 3'd0) moved = 1'b1;
        end
        chk("here_nomove", moved, 1'b0);
        chk("here_up", going_up, 1'b1);

        // At floor 3 going up with calls at 6 and 0.
        do_reset();
        call_req = 8'h08;
        @(negedge clk);
        call_req = 8'h00;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (door_open && current_floor == 3'd3) found = 1'b1;
        end
        chk("scan_reach3", found, 1'b1);
        call_req = 8'h41;
        @(negedge clk);
        call_req = 8'h00;
        chk("scan_setup", {pending, current_floor, going_up, door_open}, {8'h41, 3'd3, 1'b1, 1'b1});
        visits.delete();
        toggles = 0; cyc = 0; prev_door = 1'b1; prev_up = going_up;
        while (cyc < 300 && !(visits.size() == 2 && !door_open && !moving)) begin
            @(negedge clk);
            cyc++;
            if (door_open && !prev_door) visits.push_back(int'(current_floor));
            if (going_up != prev_up) toggles++;
            prev_door = door_open;
            prev_up   = going_up;
        end
        v0 = (visits.size() > 0) ? visits[0] : 99;
        v1 = (visits.size() > 1) ? visits[1] : 99;
        chk("scan_done", (cyc < 300), 1'b1);
        chk("scan_nvisits", visits.size(), 2);
        chk("scan_first", v0, 6);
        chk("scan_second", v1, 0);
        chk("scan_toggles", toggles, 1);

        // Same-floor calls absorbed while door open at 5; floor 7 latched.
        do_reset();
        call_req = 8'h20;
        @(negedge clk);
        call_req = 8'h00;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (door_open) found = 1'b1;
        end
        chk("absorb_reach", {found, current_floor}, {1'b1, 3'd5});
        leak = 1'b0; dcyc = 0;
        while (door_open && dcyc < 20) begin
            call_req = 8'hA0;
            @(negedge clk);
            dcyc++;
            if (pending[5]) leak = 1'b1;
        end
        call_req = 8'h00;
        chk("absorb_leak", leak, 1'b0);
        chk("absorb_door_len", dcyc, DOOR_C);
        chk("absorb_after", {pending[7], pending[5], moving, going_up, current_floor},
            {1'b1, 1'b0, 1'b1, 1'b1, 3'd5});

        // Asynchronous reset between floors 2 and 3.
        do_reset();
        call_req = 8'hF0;
        @(negedge clk);
        call_req = 8'h00;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (moving && current_floor == 3'd2) found = 1'b1;
        end
        chk("areset_setup", {found, pending}, {1'b1, 8'hF0});
        #2 rst = 1'b1;
        #1;
        chk("areset_async", {current_floor, pending, moving, going_up, door_open},
            {3'd0, 8'h00, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("areset_after", {moving, door_open, pending, current_floor}, 32'h0);

        // Five-floor, single-cycle instance: run to the top floor.
        rst5 = 1'b0;
        first_door = -1; door_cnt = 0; max_f = 0; door_floor_ok = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (door5 && first_door < 0) begin
                first_door = k;
                door_floor_ok = (floor5 == 3'd4);
            end
            if (door5) door_cnt++;
            if (int'(floor5) > max_f) max_f = int'(floor5);
            req5 = (k == 0) ? 5'h10 : 5'h00;
            @(negedge clk);
        end
        chk("p5_arrive_cycle", first_door, 6);
        chk("p5_door_floor", door_floor_ok, 1'b1);
        chk("p5_door_len", door_cnt, 1);
        chk("p5_max_floor", max_f, 4);
        chk("p5_final", {moving5, door5, pend5}, 32'h0);

        // Random traffic against the reference.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            check_model();
            chk("exclusive", moving & door_open, 1'b0);
            call_req = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            @(negedge clk);
        end
        call_req = 8'h00;
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
